// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NREQ requesters take turns
// writing bursts of up to BURST words into the write side of a FIFO.
// A grant is held until the burst completes or the owner drops its request.
// Between grants there is always exactly one IDLE arbitration cycle.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  // Index of the highest requester; also the reset value of last so that
  // the first search after reset begins at requester 0.
  localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);
  // Counter value seen during the final beat of a full burst.
  localparam logic [CW-1:0] FINAL_BEAT = CW'(BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic [DSIZE-1:0] data_arr [NREQ];
  logic [OW-1:0]    rr_pick;
  logic             rr_found;
  logic             own_req;
  logic             last_beat;

  // Unpack the flat request data bus and decode the one-hot acknowledge.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
      assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
      assign ack[gi]      = winc & (owner_q == OW'(gi));
    end
  endgenerate

  assign busy      = (state_q == OWN);
  assign owner     = owner_q;
  assign own_req   = req[owner_q];
  // Write only when the owner still has data and the FIFO has room; the
  // reset term keeps the write off in the very cycle reset is applied.
  assign winc      = busy & own_req & ~wfull & wrst_n;
  assign wdata     = busy ? data_arr[owner_q] : '0;
  assign last_beat = winc & (cnt_q == FINAL_BEAT);

  // Round-robin search: scan last+1, last+2, ... wrapping at NREQ-1.
  always_comb begin
    logic [OW-1:0] idx;
    rr_pick  = '0;
    rr_found = 1'b0;
    idx      = last_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_pick  = idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats and release in OWN.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = OWN;
          owner_d = rr_pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (winc) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A stalled owner (wfull) keeps the grant while it still requests.
        if (last_beat || !own_req) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any burst immediately.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_IDX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus a randomized run
// checked against a behavioural grant/burst model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int OW    = $clog2(NREQ);

  logic                    wclk;
  logic                    wrst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic [NREQ-1:0]         ack;
  logic                    wfull;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic [OW-1:0]           owner;
  logic                    busy;

  logic [DSIZE-1:0] stim_data [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit              m_busy;
  int              m_owner;
  int              m_last;
  int              m_beats;
  logic            exp_winc;
  logic [NREQ-1:0] exp_ack;
  logic [DSIZE-1:0] exp_wdata;

  // FIFO model and scoreboard
  bit               sb_en = 1'b0;
  logic [DSIZE-1:0] fifo_q [$];
  logic [DSIZE-1:0] exp_q  [$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .owner    (owner),
    .busy     (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = stim_data[i];
  end

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_beats = 0;
  endfunction

  function automatic void model_eval();
    exp_winc  = m_busy && req[m_owner] && !wfull && wrst_n;
    exp_ack   = exp_winc ? (NREQ'(1) << m_owner) : '0;
    exp_wdata = m_busy ? stim_data[m_owner] : '0;
  endfunction

  function automatic void model_edge();
    if (!wrst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (req != 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int cand = (m_last + k) % NREQ;
          if (req[cand]) begin
            m_owner = cand;
            break;
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else begin
      if (exp_winc) m_beats++;
      if ((exp_winc && m_beats == BURST) || !req[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endfunction

  // Advance one clock: update the models with the pre-edge inputs.
  task automatic tick();
    model_eval();
    if (sb_en) begin
      if (winc && !wfull) fifo_q.push_back(wdata);
      if (exp_winc) exp_q.push_back(stim_data[m_owner]);
    end
    model_edge();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req    = '0;
    wfull  = 1'b0;
    model_reset();
    tick();
    tick();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    req    = '0;
    wfull  = 1'b0;
    for (int i = 0; i < NREQ; i++) stim_data[i] = '0;
    model_reset();
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (winc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b want 0", winc); end
    n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++; if (wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    do_reset();
    // No requests: stays idle.
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (busy !== 1'b0 || winc !== 1'b0 || ack !== '0) begin
        n_fail++; $display("FAIL idle_noreq: busy=%b winc=%b ack=%b want 0/0/0", busy, winc, ack);
      end
      tick();
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit pat [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    stim_data[0] = 8'hA5;
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_checks++; if (busy !== pat[c]) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, pat[c]); end
      n_checks++; if (winc !== pat[c]) begin n_fail++; $display("FAIL single_winc c%0d: got %b want %b", c, winc, pat[c]); end
      n_checks++; if (ack !== NREQ'(pat[c])) begin n_fail++; $display("FAIL single_ack c%0d: got %b want %b", c, ack, NREQ'(pat[c])); end
      n_checks++; if (wdata !== (pat[c] ? 8'hA5 : 8'h00)) begin n_fail++; $display("FAIL single_wdata c%0d: got %h", c, wdata); end
      if (pat[c]) begin
        n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL single_owner c%0d: got %0d want 0", c, owner); end
      end
      tick();
    end
    req = '0;
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) stim_data[i] = DSIZE'(8'h10 + i);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int want = g % NREQ;
      #1;
      n_checks++; if (busy !== 1'b0 || winc !== 1'b0) begin
        n_fail++; $display("FAIL rr_bubble g%0d: busy=%b winc=%b want 0/0", g, busy, winc);
      end
      tick();
      for (int b = 0; b < BURST; b++) begin
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy g%0d b%0d: got %b want 1", g, b, busy); end
        n_checks++; if (owner !== OW'(want)) begin n_fail++; $display("FAIL rr_owner g%0d b%0d: got %0d want %0d", g, b, owner, want); end
        n_checks++; if (winc !== 1'b1) begin n_fail++; $display("FAIL rr_winc g%0d b%0d: got %b want 1", g, b, winc); end
        n_checks++; if (ack !== (NREQ'(1) << want)) begin n_fail++; $display("FAIL rr_ack g%0d b%0d: got %b want %b", g, b, ack, NREQ'(1) << want); end
        n_checks++; if (wdata !== DSIZE'(8'h10 + want)) begin n_fail++; $display("FAIL rr_wdata g%0d b%0d: got %h want %h", g, b, wdata, DSIZE'(8'h10 + want)); end
        tick();
      end
    end
    req = '0;
    $display("test_round_robin done");
  endtask

  task automatic test_stall();
    do_reset();
    stim_data[2] = 8'h5A;
    req = 4'b0100;
    tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      n_checks++; if (winc !== 1'b1 || owner !== OW'(2)) begin
        n_fail++; $display("FAIL stall_pre b%0d: winc=%b owner=%0d want 1/2", b, winc, owner);
      end
      tick();
    end
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      n_checks++; if (winc !== 1'b0 || ack !== '0) begin n_fail++; $display("FAIL stall_winc s%0d: winc=%b ack=%b want 0/0", s, winc, ack); end
      n_checks++; if (busy !== 1'b1 || owner !== OW'(2)) begin n_fail++; $display("FAIL stall_own s%0d: busy=%b owner=%0d want 1/2", s, busy, owner); end
      tick();
    end
    wfull = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      n_checks++; if (winc !== 1'b1 || ack !== 4'b0100) begin
        n_fail++; $display("FAIL stall_post b%0d: winc=%b ack=%b want 1/0100", b, winc, ack);
      end
      tick();
    end
    #1;
    n_checks++; if (busy !== 1'b0 || winc !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: busy=%b winc=%b want 0/0", busy, winc);
    end
    req = '0;
    tick();
    $display("test_stall done");
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < NREQ; i++) stim_data[i] = DSIZE'(8'h20 + i);
    req = 4'b0010;
    tick();
    #1;
    n_checks++; if (winc !== 1'b1 || owner !== OW'(1)) begin
      n_fail++; $display("FAIL drop_write: winc=%b owner=%0d want 1/1", winc, owner);
    end
    tick();
    req = 4'b1001;
    #1;
    n_checks++; if (busy !== 1'b1 || winc !== 1'b0 || ack !== '0) begin
      n_fail++; $display("FAIL drop_hold: busy=%b winc=%b ack=%b want 1/0/0", busy, winc, ack);
    end
    tick();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy=%b want 0", busy); end
    tick();
    #1;
    n_checks++; if (busy !== 1'b1 || owner !== OW'(3)) begin
      n_fail++; $display("FAIL drop_next: busy=%b owner=%0d want 1/3", busy, owner);
    end
    n_checks++; if (wdata !== 8'h23) begin n_fail++; $display("FAIL drop_wdata: got %h want 23", wdata); end
    req = '0;
    tick();
    $display("test_drop done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim_data[3] = 8'hC3;
    stim_data[1] = 8'h3C;
    req = 4'b1000;
    tick();
    #1;
    n_checks++; if (winc !== 1'b1 || owner !== OW'(3)) begin
      n_fail++; $display("FAIL rmid_write: winc=%b owner=%0d want 1/3", winc, owner);
    end
    wrst_n = 1'b0;
    #1;
    n_checks++; if (winc !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
      n_fail++; $display("FAIL rmid_abort: winc=%b busy=%b ack=%b want 0/0/0", winc, busy, ack);
    end
    n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL rmid_owner_rst: got %0d want 0", owner); end
    model_reset();
    tick();
    wrst_n = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle1: busy=%b want 0", busy); end
    tick();
    #1;
    n_checks++; if (busy !== 1'b1 || owner !== OW'(3)) begin
      n_fail++; $display("FAIL rmid_regrant3: busy=%b owner=%0d want 1/3", busy, owner);
    end
    wrst_n = 1'b0;
    req = 4'b1010;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_rst2: busy=%b want 0", busy); end
    model_reset();
    tick();
    wrst_n = 1'b1;
    tick();
    #1;
    n_checks++; if (busy !== 1'b1 || owner !== OW'(1)) begin
      n_fail++; $display("FAIL rmid_grant1: busy=%b owner=%0d want 1/1", busy, owner);
    end
    n_checks++; if (wdata !== 8'h3C) begin n_fail++; $display("FAIL rmid_wdata: got %h want 3c", wdata); end
    req = '0;
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] prev_ack;
    int nmin;
    do_reset();
    fifo_q.delete();
    exp_q.delete();
    sb_en = 1'b1;
    prev_ack = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || prev_ack[i]) begin
          req[i]       = ($urandom_range(0, 99) < 60);
          stim_data[i] = DSIZE'($urandom);
        end
      end
      wfull = ($urandom_range(0, 99) < 30);
      #1;
      model_eval();
      n_checks++; if (winc !== exp_winc) begin n_fail++; $display("FAIL rnd_winc cyc%0d: got %b want %b", cyc, winc, exp_winc); end
      n_checks++; if (winc === 1'b1 && wfull === 1'b1) begin n_fail++; $display("FAIL rnd_full_write cyc%0d: winc=1 with wfull=1", cyc); end
      n_checks++; if (!$onehot0(ack)) begin n_fail++; $display("FAIL rnd_onehot cyc%0d: ack=%b", cyc, ack); end
      n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc%0d: got %b want %b", cyc, ack, exp_ack); end
      n_checks++; if (wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc%0d: got %h want %h", cyc, wdata, exp_wdata); end
      n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, m_busy); end
      if (m_busy) begin
        n_checks++; if (owner !== OW'(m_owner)) begin n_fail++; $display("FAIL rnd_owner cyc%0d: got %0d want %0d", cyc, owner, m_owner); end
      end
      prev_ack = exp_ack;
      tick();
    end
    sb_en = 1'b0;
    req = '0;
    n_checks++; if (fifo_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fifo_count: got %0d words want %0d", fifo_q.size(), exp_q.size());
    end
    n_checks++; if (exp_q.size() < 500) begin
      n_fail++; $display("FAIL fifo_volume: got %0d words want at least 500", exp_q.size());
    end
    nmin = (fifo_q.size() < exp_q.size()) ? fifo_q.size() : exp_q.size();
    for (int k = 0; k < nmin; k++) begin
      n_checks++; if (fifo_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL fifo_data[%0d]: got %h want %h", k, fifo_q[k], exp_q[k]);
      end
    end
    $display("test_random done: %0d words written", fifo_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of write requesters (2..8).
REQ-002 The block SHALL have parameter DSIZE, default 8, meaning the data word width and matching the FIFO wdata width.
REQ-003 The block SHALL have parameter BURST, default 4, meaning the maximum number of accepted writes per grant (1..16).
REQ-004 The block SHALL have a port wclk, input, 1 bit: the single clock, write domain of the FIFO.
REQ-005 The block SHALL have a port wrst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have a port req, input, NREQ bits: per-requester data-valid.
REQ-007 The block SHALL have a port req_data, input, NREQ*DSIZE bits: requester i data in bits [i*DSIZE +: DSIZE].
REQ-008 The block SHALL have a port ack, output, NREQ bits: one-hot or zero; ack[i]=1 means req_data[i] is written this cycle.
REQ-009 The block SHALL have a port wfull, input, 1 bit: FIFO full flag.
REQ-010 The block SHALL have a port winc, output, 1 bit: FIFO write enable.
REQ-011 The block SHALL have a port wdata, output, DSIZE bits: FIFO write data.
REQ-012 The block SHALL have a port owner, output, $clog2(NREQ) bits: index of the current grant holder, valid while busy=1.
REQ-013 The block SHALL have a port busy, output, 1 bit: 1 while in state OWN.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and OWN.
REQ-015 In IDLE with req!=0, the FSM SHALL go to OWN at the next edge with owner = first i with req[i]=1, searching last+1, last+2, ... modulo NREQ (round-robin); last is the previous owner.
REQ-016 In IDLE with req=0, the FSM SHALL remain in IDLE; winc=0 and ack=0.
REQ-017 In OWN, winc SHALL be combinational: winc = req[owner] & !wfull.
REQ-018 In OWN, ack[owner] SHALL equal winc; all other ack bits SHALL be 0.
REQ-019 wdata SHALL equal req_data[owner] in OWN and SHALL be 0 in IDLE.
REQ-020 A beat counter (width $clog2(BURST+1)) SHALL clear on entry to OWN and increment by 1 on each cycle with winc=1.
REQ-021 OWN SHALL go to IDLE at the edge where winc=1 and the counter reaches BURST.
REQ-022 OWN SHALL also go to IDLE at any edge where req[owner]=0.
REQ-023 On either release, last SHALL be updated to owner.
REQ-024 wfull=1 in OWN SHALL stall: winc=0, counter held, ownership kept indefinitely while req[owner]=1.
REQ-025 Every grant SHALL be followed by exactly one IDLE (arbitration) cycle; requests arriving during OWN SHALL wait for it.
REQ-026 Requests from non-owners SHALL neither preempt the owner nor affect owner selection until IDLE.
REQ-027 Round-robin wrap-around: with last=NREQ-1, the search SHALL start at 0.
REQ-028 The block SHALL never assert winc while wfull=1, so no write is dropped by the FIFO.
REQ-029 Requesters SHALL hold req and req_data stable until ack; a req_data change while req=1 and ack=0 is a protocol violation and not checked by the block.

Reset
REQ-030 wrst_n=0 SHALL asynchronously force state=IDLE, counter=0, last=NREQ-1, owner=0 and busy=0; winc and ack SHALL then read 0 combinationally.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately; the write in the reset cycle SHALL NOT occur.
REQ-032 After wrst_n deassertion, the first grant SHALL go to the lowest-index requesting port.

Verification
REQ-033 The bench SHALL cover: reset, then req=4'b0001 held with wfull=0 -> IDLE 1 cycle, then 4 consecutive winc/ack[0], then one IDLE cycle, then owner 0 regranted.
REQ-034 The bench SHALL cover: req=4'b1111 held, wfull=0 -> grants in order 0,1,2,3,0, each grant 4 writes, 1 bubble cycle between grants.
REQ-035 The bench SHALL cover: owner 2 after 2 writes, wfull=1 for 5 cycles -> winc=0, counter=2 held, owner=2; after wfull=0, exactly 2 more writes, then release.
REQ-036 The bench SHALL cover: owner 1 drops req after 1 write -> IDLE next edge; with req=4'b1001 pending, next owner=3.
REQ-037 The bench SHALL cover: wrst_n pulled low during a write cycle of owner 3 -> winc=0 and busy=0 in the same cycle; after release with req=4'b1000, owner=3 granted, and with req=4'b1010, owner=1.
REQ-038 The bench SHALL cover, with a FIFO model attached and random req/wfull over 10k cycles: no winc while wfull=1, ack always one-hot or zero, and FIFO contents equal the per-requester acked data in order.
